// File: rtl/rv_defines_pkg.sv
// RV32I/RV32M decode constants, divider state encoding and the shared ALU helper
// used by the execute stage.
package rv_defines_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // RV32M funct3 (funct3[2] set selects the divider)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        DivIdle,
        DivCalc,
        DivDone
    } div_state_e;

    // alt selects SUB for ADD and SRA for the right shift
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            F3_ADD:  return alt ? a - b : a + b;
            F3_SLL:  return a << b[4:0];
            F3_SLT:  return {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: return {31'b0, a < b};
            F3_XOR:  return a ^ b;
            F3_SR:   return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:   return a | b;
            default: return a & b;
        endcase
    endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX operand bundle into the execute stage and the writeback/redirect/stall
// results back out. master = pipeline side, slave = ex.
interface ex_if;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        reg_wen_o;
    logic [31:0] jump_addr_o;
    logic        jump_en_o;
    logic        hold_flag_o;

    modport master (
        output inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
        input  rd_addr_o, rd_data_o, reg_wen_o, jump_addr_o, jump_en_o, hold_flag_o
    );

    modport slave (
        input  inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
        output rd_addr_o, rd_data_o, reg_wen_o, jump_addr_o, jump_en_o, hold_flag_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle
// on operand magnitudes, signs applied on the way out. Only built with RV32M_EN.
module ex_div
    import rv_defines_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,        // [0]: unsigned, [1]: remainder
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state_q, state_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial, diff;

    assign a_neg = ~op[0] & dividend[31];
    assign b_neg = ~op[0] & divisor[31];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    // Partial remainder with the next dividend bit shifted in; no borrow means subtract
    assign trial = {rem_q, dvd_q[31]};
    assign diff  = trial - {1'b0, dvs_q};

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        unique case (state_q)
            DivIdle: begin
                if (start) begin
                    is_rem_d = op[1];
                    if (divisor == 32'd0) begin
                        // x/0: fixed quotient, raw dividend as remainder, no sign fix-up
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = dividend;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = DivDone;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        quo_d   = 32'd0;
                        rem_d   = 32'd0;
                        cnt_d   = 5'd0;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        state_d = DivCalc;
                    end
                end
            end
            DivCalc: begin
                dvd_d = {dvd_q[30:0], 1'b0};
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DivDone;
                end
            end
            DivDone: state_d = DivIdle;
            default: state_d = DivIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DivIdle;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            quo_q    <= 32'd0;
            rem_q    <= 32'd0;
            cnt_q    <= 5'd0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

    assign busy   = ((state_q == DivIdle) && start) || (state_q == DivCalc);
    assign done   = (state_q == DivDone);
    assign result = is_rem_q ? (neg_r_q ? -rem_q : rem_q) : (neg_q_q ? -quo_q : quo_q);

endmodule

// File: rtl/ex.sv
// RV32I execute stage: single-cycle ALU/branch/jump plus optional RV32M.
// Macro RV32M_EN: adds single-cycle MUL* and the iterative ex_div divider.
module ex
    import rv_defines_pkg::*;
(
    input logic clk,
    input logic rst_n,
    ex_if.slave bus
);

    logic [31:0] inst, pc, op1, op2;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] b_imm, j_imm, pc_plus4;
    logic        br_taken;
    logic        writes;
    logic [31:0] rd_data;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        div_busy;

    assign inst     = bus.inst_i;
    assign pc       = bus.inst_addr_i;
    assign op1      = bus.op1_i;
    assign op2      = bus.op2_i;
    assign opcode   = inst[6:0];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign b_imm    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

`ifdef RV32M_EN
    logic        div_start, div_done;
    logic [31:0] div_result, mul_res;
    logic [32:0] mul_a, mul_b;
    logic [63:0] mul_p;

    assign div_start = (opcode == OPC_OP) && (f7 == F7_MULDIV) && f3[2];

    // Signed/unsigned 33-bit extension lets one multiplier cover all MUL variants
    always_comb begin
        mul_a   = {((f3 == F3_MULH) || (f3 == F3_MULHSU)) & op1[31], op1};
        mul_b   = {(f3 == F3_MULH) & op2[31], op2};
        mul_p   = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};
        mul_res = (f3 == F3_MUL) ? mul_p[31:0] : mul_p[63:32];
    end

    ex_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .op       (f3[1:0]),
        .dividend (op1),
        .divisor  (op2),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign div_busy   = 1'b0;
`endif

    // Branch comparator
    always_comb begin
        case (f3)
            F3_BEQ:  br_taken = (op1 == op2);
            F3_BNE:  br_taken = (op1 != op2);
            F3_BLT:  br_taken = ($signed(op1) < $signed(op2));
            F3_BGE:  br_taken = ($signed(op1) >= $signed(op2));
            F3_BLTU: br_taken = (op1 < op2);
            F3_BGEU: br_taken = (op1 >= op2);
            default: br_taken = 1'b0;
        endcase
    end

    // Opcode decode to writeback data and redirect
    always_comb begin
        writes    = 1'b0;
        rd_data   = 32'd0;
        jump_en   = 1'b0;
        jump_addr = 32'd0;
        case (opcode)
            OPC_OP_IMM: begin
                writes  = 1'b1;
                rd_data = alu(f3, (f3 == F3_SR) & inst[30], op1, op2);
            end
            OPC_OP: begin
                if ((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)))) begin
                    writes  = 1'b1;
                    rd_data = alu(f3, inst[30], op1, op2);
                end
`ifdef RV32M_EN
                else if (f7 == F7_MULDIV) begin
                    if (!f3[2]) begin
                        writes  = 1'b1;
                        rd_data = mul_res;
                    end else if (div_done) begin
                        writes  = 1'b1;
                        rd_data = div_result;
                    end
                end
`endif
            end
            OPC_LUI, OPC_AUIPC: begin
                writes  = 1'b1;
                rd_data = op1 + op2;
            end
            OPC_JAL: begin
                writes    = 1'b1;
                rd_data   = pc_plus4;
                jump_en   = 1'b1;
                jump_addr = pc + j_imm;
            end
            OPC_JALR: begin
                writes    = 1'b1;
                rd_data   = pc_plus4;
                jump_en   = 1'b1;
                jump_addr = (op1 + op2) & ~32'd1;
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    jump_en   = 1'b1;
                    jump_addr = pc + b_imm;
                end
            end
            default: ;
        endcase
    end

    // Everything is forced low while reset is asserted, combinational paths included
    assign bus.rd_addr_o   = (rst_n && writes) ? bus.rd_addr_i : 5'd0;
    assign bus.rd_data_o   = rst_n ? rd_data : 32'd0;
    assign bus.reg_wen_o   = rst_n & writes & bus.reg_wen_i;
    assign bus.jump_en_o   = rst_n & jump_en;
    assign bus.jump_addr_o = rst_n ? jump_addr : 32'd0;
    assign bus.hold_flag_o = rst_n & div_busy;

endmodule

// File: tb/tb_ex.sv
// Directed self-checking bench for the execute stage; divider checks need RV32M_EN.
module tb_ex;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ex_if bus ();

    ex dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm, 5'd1, f3, 5'd3, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    // Present one instruction just after a rising edge, return at the following falling edge
    task automatic apply(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic wen);
        @(posedge clk);
        #1;
        bus.inst_i      = inst;
        bus.inst_addr_i = pc;
        bus.op1_i       = a;
        bus.op2_i       = b;
        bus.rd_addr_i   = rd;
        bus.reg_wen_i   = wen;
        @(negedge clk);
    endtask

`ifdef RV32M_EN
    task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input int exp_hold);
        int   n;
        logic noisy;
        n     = 0;
        noisy = 1'b0;
        apply(enc_r(7'b0000001, f3), 32'h300, a, b, 5'd4, 1'b1);
        while (bus.hold_flag_o === 1'b1 && n < 100) begin
            n++;
            if (bus.reg_wen_o !== 1'b0 || bus.jump_en_o !== 1'b0) noisy = 1'b1;
            @(negedge clk);
        end
        check({tag, "_hold_cycles"}, n, exp_hold);
        check({tag, "_quiet_while_hold"}, {31'd0, noisy}, 32'd0);
        check({tag, "_wen"}, {31'd0, bus.reg_wen_o}, 32'd1);
        check({tag, "_data"}, bus.rd_data_o, exp_res);
        check({tag, "_rd"}, {27'd0, bus.rd_addr_o}, 32'd4);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        // Reset held with a JAL presented: all outputs must stay 0
        rst_n           = 1'b0;
        bus.inst_i      = enc_j(21'h10);
        bus.inst_addr_i = 32'h80;
        bus.op1_i       = 32'd1;
        bus.op2_i       = 32'd2;
        bus.rd_addr_i   = 5'd1;
        bus.reg_wen_i   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        check("rst_data", bus.rd_data_o, 32'd0);
        check("rst_jump", {31'd0, bus.jump_en_o}, 32'd0);
        check("rst_jaddr", bus.jump_addr_o, 32'd0);
        check("rst_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        rst_n = 1'b1;

        // ADDI x1 = 5 + (-3)
        apply(enc_i(12'hFFD, 3'b000, 7'b0010011), 32'h10, 32'd5, 32'hFFFF_FFFD, 5'd1, 1'b1);
        check("addi_data", bus.rd_data_o, 32'd2);
        check("addi_wen", {31'd0, bus.reg_wen_o}, 32'd1);
        check("addi_rd", {27'd0, bus.rd_addr_o}, 32'd1);
        check("addi_jump", {31'd0, bus.jump_en_o}, 32'd0);

        // BNE taken, +8
        apply(enc_b(13'd8, 3'b001), 32'h100, 32'd1, 32'd2, 5'd0, 1'b1);
        check("bne_jump", {31'd0, bus.jump_en_o}, 32'd1);
        check("bne_addr", bus.jump_addr_o, 32'h108);
        check("bne_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        // BNE not taken
        apply(enc_b(13'd8, 3'b001), 32'h100, 32'd7, 32'd7, 5'd0, 1'b0);
        check("bne_nt_jump", {31'd0, bus.jump_en_o}, 32'd0);
        // BLT -1 < 1 signed, -4 offset
        apply(enc_b(13'h1FFC, 3'b100), 32'h200, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        check("blt_jump", {31'd0, bus.jump_en_o}, 32'd1);
        check("blt_addr", bus.jump_addr_o, 32'h1FC);
        // BLTU 0xFFFFFFFF < 1 unsigned is false
        apply(enc_b(13'h1FFC, 3'b110), 32'h200, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        check("bltu_jump", {31'd0, bus.jump_en_o}, 32'd0);

        // JALR clears bit 0 of the target
        apply(enc_i(12'd4, 3'b000, 7'b1100111), 32'h40, 32'h203, 32'd4, 5'd5, 1'b1);
        check("jalr_addr", bus.jump_addr_o, 32'h206);
        check("jalr_data", bus.rd_data_o, 32'h44);
        check("jalr_jump", {31'd0, bus.jump_en_o}, 32'd1);
        check("jalr_wen", {31'd0, bus.reg_wen_o}, 32'd1);
        // JAL +0x10
        apply(enc_j(21'h10), 32'h80, 32'd0, 32'd0, 5'd1, 1'b1);
        check("jal_addr", bus.jump_addr_o, 32'h90);
        check("jal_data", bus.rd_data_o, 32'h84);

        // R-type SRA, SUB, SLTU
        apply(enc_r(7'b0100000, 3'b101), 32'h0, 32'h8000_0000, 32'd4, 5'd3, 1'b1);
        check("sra_data", bus.rd_data_o, 32'hF800_0000);
        apply(enc_r(7'b0000000, 3'b101), 32'h0, 32'h8000_0000, 32'd36, 5'd3, 1'b1);
        check("srl_data", bus.rd_data_o, 32'h0800_0000);
        apply(enc_r(7'b0100000, 3'b000), 32'h0, 32'd3, 32'd5, 5'd3, 1'b1);
        check("sub_data", bus.rd_data_o, 32'hFFFF_FFFE);
        apply(enc_r(7'b0000000, 3'b011), 32'h0, 32'd3, 32'hFFFF_FFFF, 5'd3, 1'b1);
        check("sltu_data", bus.rd_data_o, 32'd1);
        // SRAI with imm[10] set and ADDI with the same bit set must differ
        apply(enc_i(12'h401, 3'b000, 7'b0010011), 32'h0, 32'd1, 32'h401, 5'd3, 1'b1);
        check("addi_hi_data", bus.rd_data_o, 32'h402);

        // LUI: op1 is 0
        apply({20'h12345, 5'd3, 7'b0110111}, 32'h0, 32'd0, 32'h1234_5000, 5'd3, 1'b1);
        check("lui_data", bus.rd_data_o, 32'h1234_5000);
        // Store: no writeback, no jump
        apply(32'h0020_A023, 32'h0, 32'd9, 32'd4, 5'd0, 1'b1);
        check("store_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        // Unknown opcode: everything 0
        apply(32'hFFFF_FFFF, 32'h44, 32'd9, 32'd4, 5'd7, 1'b1);
        check("unk_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        check("unk_data", bus.rd_data_o, 32'd0);
        check("unk_rd", {27'd0, bus.rd_addr_o}, 32'd0);
        check("unk_jump", {31'd0, bus.jump_en_o}, 32'd0);

`ifdef RV32M_EN
        apply(enc_r(7'b0000001, 3'b000), 32'h0, 32'hFFFF_FFFF, 32'd3, 5'd3, 1'b1);
        check("mul_data", bus.rd_data_o, 32'hFFFF_FFFD);
        apply(enc_r(7'b0000001, 3'b001), 32'h0, 32'hFFFF_FFFF, 32'd3, 5'd3, 1'b1);
        check("mulh_data", bus.rd_data_o, 32'hFFFF_FFFF);
        apply(enc_r(7'b0000001, 3'b011), 32'h0, 32'hFFFF_FFFF, 32'd3, 5'd3, 1'b1);
        check("mulhu_data", bus.rd_data_o, 32'd2);

        // Back-to-back DIV then REM, then the special cases
        run_div("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_div("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_div("divu0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
        run_div("remu0", 3'b111, 32'd9, 32'd0, 32'd9, 1);
        run_div("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_div("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_div("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Reset at CALC cycle 10
        apply(enc_r(7'b0000001, 3'b100), 32'h300, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
        repeat (10) @(negedge clk);
        check("pre_rst_hold", {31'd0, bus.hold_flag_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        check("midrst_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        check("midrst_data", bus.rd_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h0000_0013, 32'h304, 32'd0, 32'd0, 5'd0, 1'b0);
        check("nop_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        check("nop_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        run_div("div_after_rst", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
`else
        // Without RV32M the M-extension encodings are unknown instructions
        apply(enc_r(7'b0000001, 3'b100), 32'h300, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
        check("nom_div_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        check("nom_div_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        check("nom_div_data", bus.rd_data_o, 32'd0);
        @(negedge clk);
        check("nom_div_hold2", {31'd0, bus.hold_flag_o}, 32'd0);
        apply(enc_r(7'b0000001, 3'b000), 32'h0, 32'd6, 32'd7, 5'd3, 1'b1);
        check("nom_mul_wen", {31'd0, bus.reg_wen_o}, 32'd0);
        check("nom_mul_data", bus.rd_data_o, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
